// File: rtl/debug_unit_program_loader.sv
// Receives a program over UART (CMD_LOAD, then little-endian 32-bit words) and writes
// it to instruction memory; ends on HALT, overflow or timeout and replies ACK/NAK.
module debug_unit_program_loader #(
  parameter int                   NB_DATA        = 32,
  parameter int                   NB_BYTE        = 8,
  parameter int                   NB_ADDR        = 10,
  parameter int                   NB_STATE       = 3,
  parameter int                   NB_TIMEOUT     = 24,
  parameter int                   TIMEOUT_CYCLES = 1000000,
  parameter logic [NB_BYTE-1:0]   CMD_LOAD       = 8'h4C,
  parameter logic [NB_DATA-1:0]   HALT_INSTR     = 32'hFFFFFFFF,
  parameter logic [NB_BYTE-1:0]   ACK_BYTE       = 8'h06,
  parameter logic [NB_BYTE-1:0]   NAK_BYTE       = 8'h15
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [NB_BYTE-1:0]   i_rx_data,
  input  logic                 i_rx_done,
  input  logic                 i_tx_8b_done,
  output logic                 o_imem_wr_en,
  output logic [NB_ADDR-1:0]   o_imem_wr_addr,
  output logic [NB_DATA-1:0]   o_imem_wr_data,
  output logic [NB_BYTE-1:0]   o_tx_data,
  output logic                 o_tx_8b_start,
  output logic                 o_loading,
  output logic                 o_load_done,
  output logic                 o_error,
  output logic [NB_ADDR:0]     o_word_count,
  output logic [NB_STATE-1:0]  o_state
);
  localparam int NBYTES  = NB_DATA / NB_BYTE;
  localparam int NB_BCNT = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [NB_STATE-1:0] S_IDLE  = NB_STATE'(0);
  localparam logic [NB_STATE-1:0] S_RECV  = NB_STATE'(1);
  localparam logic [NB_STATE-1:0] S_WRITE = NB_STATE'(2);
  localparam logic [NB_STATE-1:0] S_SEND  = NB_STATE'(3);
  localparam logic [NB_STATE-1:0] S_WAIT  = NB_STATE'(4);

  localparam logic [NB_BCNT-1:0]    LAST_BYTE = NB_BCNT'(NBYTES - 1);
  localparam logic [NB_TIMEOUT-1:0] TO_LAST   = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  logic [NB_STATE-1:0]   r_state, w_state_nxt;
  logic [NB_ADDR-1:0]    r_addr, r_wr_addr;
  logic [NB_DATA-1:0]    r_word, r_wr_data, w_word_nxt;
  logic [NB_BCNT-1:0]    r_byte_cnt;
  logic [NB_TIMEOUT-1:0] r_timeout;
  logic [NB_ADDR:0]      r_word_count;
  logic                  r_error, r_load_done;
  logic                  w_cmd, w_last_byte, w_timeout, w_halt, w_addr_max;

  assign w_cmd       = i_rx_done && (i_rx_data == CMD_LOAD);
  assign w_last_byte = i_rx_done && (r_byte_cnt == LAST_BYTE);
  // A byte arriving in the expiry cycle takes priority over the abort.
  assign w_timeout   = !i_rx_done && (r_timeout == TO_LAST);
  assign w_halt      = (r_wr_data == HALT_INSTR);
  assign w_addr_max  = (r_addr == {NB_ADDR{1'b1}});

  always_comb begin
    w_word_nxt = r_word;
    w_word_nxt[int'(r_byte_cnt)*NB_BYTE +: NB_BYTE] = i_rx_data;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_cmd) w_state_nxt = S_RECV;
      S_RECV:  if (w_last_byte) w_state_nxt = S_WRITE;
               else if (w_timeout) w_state_nxt = S_SEND;
      S_WRITE: w_state_nxt = (w_halt || w_addr_max) ? S_SEND : S_RECV;
      S_SEND:  w_state_nxt = S_WAIT;
      S_WAIT:  if (i_tx_8b_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_imem_wr_en  = (r_state == S_WRITE);
    o_tx_8b_start = (r_state == S_SEND);
    o_loading     = (r_state != S_IDLE);
    o_tx_data     = '0;
    if (r_state == S_SEND || r_state == S_WAIT) o_tx_data = r_error ? NAK_BYTE : ACK_BYTE;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_addr       <= '0;
      r_wr_addr    <= '0;
      r_word       <= '0;
      r_wr_data    <= '0;
      r_byte_cnt   <= '0;
      r_timeout    <= '0;
      r_word_count <= '0;
      r_error      <= 1'b0;
      r_load_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_cmd) begin
          r_addr       <= '0;
          r_byte_cnt   <= '0;
          r_timeout    <= '0;
          r_word_count <= '0;
          r_error      <= 1'b0;
          r_load_done  <= 1'b0;
        end
        S_RECV: if (i_rx_done) begin
          r_word     <= w_word_nxt;
          r_byte_cnt <= r_byte_cnt + 1'b1;
          r_timeout  <= '0;
          if (w_last_byte) begin
            r_wr_addr <= r_addr;
            r_wr_data <= w_word_nxt;
          end
        end else begin
          r_timeout <= r_timeout + 1'b1;
          if (w_timeout) r_error <= 1'b1;
        end
        S_WRITE: begin
          r_word_count <= r_word_count + 1'b1;
          r_byte_cnt   <= '0;
          if (!w_halt) begin
            if (w_addr_max) r_error <= 1'b1;
            else            r_addr  <= r_addr + 1'b1;
          end
        end
        S_WAIT: if (i_tx_8b_done) r_load_done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign o_imem_wr_addr = r_wr_addr;
  assign o_imem_wr_data = r_wr_data;
  assign o_load_done    = r_load_done;
  assign o_error        = r_error;
  assign o_word_count   = r_word_count;
  assign o_state        = r_state;
endmodule

// File: tb/tb_debug_unit_program_loader.sv
// Directed bench for the program loader, built with a 4-word memory and 100-cycle timeout.
module tb_debug_unit_program_loader;
  logic       i_clock = 1'b0, i_reset = 1'b1;
  logic [7:0] i_rx_data = '0;
  logic       i_rx_done = 1'b0, i_tx_8b_done = 1'b0;
  logic       o_imem_wr_en, o_tx_8b_start, o_loading, o_load_done, o_error;
  logic [1:0] o_imem_wr_addr;
  logic [31:0] o_imem_wr_data;
  logic [7:0] o_tx_data;
  logic [2:0] o_word_count, o_state;

  int n_vec = 0, n_miss = 0;
  int n_wr = 0, n_start = 0, b_wr, b_start;
  logic [7:0] last_tx = '0;

  debug_unit_program_loader #(.NB_ADDR(2), .TIMEOUT_CYCLES(100)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .i_tx_8b_done(i_tx_8b_done), .o_imem_wr_en(o_imem_wr_en), .o_imem_wr_addr(o_imem_wr_addr),
    .o_imem_wr_data(o_imem_wr_data), .o_tx_data(o_tx_data), .o_tx_8b_start(o_tx_8b_start),
    .o_loading(o_loading), .o_load_done(o_load_done), .o_error(o_error),
    .o_word_count(o_word_count), .o_state(o_state));

  always #5 i_clock = ~i_clock;

  always @(negedge i_clock) begin
    if (o_imem_wr_en) n_wr++;
    if (o_tx_8b_start) begin n_start++; last_tx = o_tx_data; end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clock);
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b; i_rx_done = 1'b1;
    @(negedge i_clock);
    i_rx_done = 1'b0; i_rx_data = '0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit dochk, input logic [1:0] a);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[k*8 +: 8]);
      if (k < 3) idle(1);
    end
    if (dochk) begin
      chk("wr_en", o_imem_wr_en, 1'b1);
      chk("wr_addr", o_imem_wr_addr, a);
      chk("wr_data", o_imem_wr_data, w);
    end
    idle(1);
  endtask

  task automatic wait_state(input logic [2:0] s);
    for (int i = 0; i < 300 && o_state != s; i++) @(negedge i_clock);
    chk("wait_state", o_state, s);
  endtask

  task automatic begin_load();
    b_wr = n_wr; b_start = n_start;
    send_byte(8'h4C);
    chk("cmd_state", o_state, 3'd1);
    chk("cmd_loading", o_loading, 1'b1);
    chk("cmd_load_done_clr", o_load_done, 1'b0);
    chk("cmd_wc_clr", o_word_count, 3'd0);
    idle(1);
  endtask

  task automatic respond(input logic [7:0] tx, input bit err, input int nw, input logic [2:0] wc);
    wait_state(3'd4);
    chk("resp_tx_held", o_tx_data, tx);
    chk("resp_start_pulses", n_start - b_start, 1);
    chk("resp_start_data", last_tx, tx);
    chk("resp_error", o_error, err);
    chk("resp_writes", n_wr - b_wr, nw);
    chk("resp_wc", o_word_count, wc);
    i_tx_8b_done = 1'b1;
    @(negedge i_clock);
    i_tx_8b_done = 1'b0;
    chk("resp_idle", o_state, 3'd0);
    chk("resp_load_done", o_load_done, 1'b1);
    chk("resp_loading", o_loading, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, o_state, 3'd0);
    chk({tag, "_outs"}, {o_imem_wr_en, o_imem_wr_addr, o_imem_wr_data, o_tx_data,
        o_tx_8b_start, o_loading, o_load_done, o_error, o_word_count}, 64'd0);
  endtask

  initial begin
    idle(2);
    chk_all_zero("reset");
    i_reset = 1'b0;
    idle(1);

    // Basic load
    begin_load();
    send_word(32'h20000013, 1'b1, 2'd0);
    send_word(32'hFFFFFFFF, 1'b1, 2'd1);
    respond(8'h06, 1'b0, 2, 3'd2);

    // Non-command bytes in IDLE are ignored
    b_wr = n_wr; b_start = n_start;
    send_byte(8'h00); idle(1);
    send_byte(8'h41); idle(1);
    send_byte(8'hFF); idle(2);
    chk("filt_state", o_state, 3'd0);
    chk("filt_activity", (n_wr - b_wr) + (n_start - b_start), 0);
    chk("filt_load_done_kept", o_load_done, 1'b1);
    begin_load();
    send_word(32'hFFFFFFFF, 1'b1, 2'd0);
    respond(8'h06, 1'b0, 1, 3'd1);

    // Overflow: fifth word arrives after the NAK is under way
    begin_load();
    for (int i = 1; i <= 4; i++) send_word(32'(i), 1'b1, 2'(i - 1));
    send_word(32'h5, 1'b0, 2'd0);
    respond(8'h15, 1'b1, 4, 3'd4);

    // HALT at the last address is a success
    begin_load();
    for (int i = 0; i < 3; i++) send_word(32'hA0 + 32'(i), 1'b1, 2'(i));
    send_word(32'hFFFFFFFF, 1'b1, 2'd3);
    respond(8'h06, 1'b0, 4, 3'd4);

    // Timeout: abort takes effect after 100 silent cycles
    begin_load();
    send_byte(8'hAA); idle(1);
    send_byte(8'hBB);
    idle(99);
    chk("to_not_yet", o_state, 3'd1);
    idle(1);
    chk("to_send_state", o_state, 3'd3);
    chk("to_start", o_tx_8b_start, 1'b1);
    chk("to_nak", o_tx_data, 8'h15);
    respond(8'h15, 1'b1, 0, 3'd0);

    // A byte in the expiry cycle is accepted and restarts the count
    begin_load();
    send_byte(8'hAA); idle(1);
    send_byte(8'hBB);
    idle(99);
    send_byte(8'hCC);
    chk("to_edge_state", o_state, 3'd1);
    chk("to_edge_err", o_error, 1'b0);
    idle(99);
    send_byte(8'hDD);
    chk("to_edge_wr", o_imem_wr_en, 1'b1);
    chk("to_edge_data", o_imem_wr_data, 32'hDDCCBBAA);
    idle(1);
    send_word(32'hFFFFFFFF, 1'b1, 2'd1);
    respond(8'h06, 1'b0, 2, 3'd2);

    // Reset mid-load discards the partial word
    begin_load();
    send_byte(8'h11); idle(1);
    send_byte(8'h22);
    b_wr = n_wr;
    i_reset = 1'b1;
    #1;
    chk_all_zero("rst_async");
    @(negedge i_clock);
    i_reset = 1'b0;
    idle(1);
    chk_all_zero("rst_after");
    chk("rst_no_write", n_wr - b_wr, 0);
    begin_load();
    send_word(32'hFFFFFFFF, 1'b1, 2'd0);
    respond(8'h06, 1'b0, 1, 3'd1);

    // Back-to-back loads with a stray byte during the response wait
    begin_load();
    send_word(32'hFFFFFFFF, 1'b1, 2'd0);
    wait_state(3'd4);
    send_byte(8'h4C);
    chk("stray_state", o_state, 3'd4);
    respond(8'h06, 1'b0, 1, 3'd1);
    begin_load();
    send_word(32'h12345678, 1'b1, 2'd0);
    send_word(32'h9ABCDEF0, 1'b1, 2'd1);
    send_word(32'hFFFFFFFF, 1'b1, 2'd2);
    respond(8'h06, 1'b0, 3, 3'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
